sum_bcd_converter: RTL and testbench

SUM_BCD_CONVERTER -- requirements
Module: sum_bcd_converter

---
 rtl/sum_bcd_converter.sv | 104 ++++++++++
 tb/tb_sum_bcd_converter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_bcd_converter.sv
// Sequential double-dabble converter: turns a 7-bit binary sum (0..127)
// into hundreds/tens/ones BCD digits, one shift step per clock.
module sum_bcd_converter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] bin,
    output logic       busy,
    output logic       done,
    output logic       hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0] state_q, state_d;
    logic [2:0] count_q, count_d;
    logic [6:0] bin_sr_q, bin_sr_d;
    logic [8:0] scratch_q, scratch_d;
    logic       done_q, done_d;
    logic       hundreds_q, hundreds_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;

    logic [3:0] tens_adj;
    logic [3:0] ones_adj;

    // The hundreds position never reaches 5 for inputs up to 127, so only
    // the tens and ones nibbles need the add-3 correction.
    assign tens_adj = (scratch_q[7:4] >= 4'd5) ? scratch_q[7:4] + 4'd3 : scratch_q[7:4];
    assign ones_adj = (scratch_q[3:0] >= 4'd5) ? scratch_q[3:0] + 4'd3 : scratch_q[3:0];

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        bin_sr_d   = bin_sr_q;
        scratch_d  = scratch_q;
        done_d     = 1'b0;
        hundreds_d = hundreds_q;
        tens_d     = tens_q;
        ones_d     = ones_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_sr_d  = bin;
                    scratch_d = 9'd0;
                    count_d   = 3'd7;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = {tens_adj, ones_adj, bin_sr_q[6]};
                bin_sr_d  = {bin_sr_q[5:0], 1'b0};
                count_d   = count_q - 3'd1;
                if (count_q == 3'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                hundreds_d = scratch_q[8];
                tens_d     = scratch_q[7:4];
                ones_d     = scratch_q[3:0];
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= 3'd0;
            bin_sr_q   <= 7'd0;
            scratch_q  <= 9'd0;
            done_q     <= 1'b0;
            hundreds_q <= 1'b0;
            tens_q     <= 4'd0;
            ones_q     <= 4'd0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            bin_sr_q   <= bin_sr_d;
            scratch_q  <= scratch_d;
            done_q     <= done_d;
            hundreds_q <= hundreds_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
        end
    end

    assign busy     = (state_q == SHIFT) || (state_q == DONE);
    assign done     = done_q;
    assign hundreds = hundreds_q;
    assign tens     = tens_q;
    assign ones     = ones_q;

endmodule

// File: tb/tb_sum_bcd_converter.sv
// Scoreboard bench for sum_bcd_converter: expected digits are queued when a
// start is driven and compared when done pulses.
module tb_sum_bcd_converter;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [6:0] bin;
    logic       busy;
    logic       done;
    logic       hundreds;
    logic [3:0] tens;
    logic [3:0] ones;

    int total;
    int bad;
    logic [8:0] sb[$];

    sum_bcd_converter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .hundreds (hundreds),
        .tens     (tens),
        .ones     (ones)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference digits computed arithmetically, packed as {hundreds, tens, ones}.
    function automatic logic [8:0] ref_bcd(input int v);
        logic [8:0] r;
        r[8]   = (v >= 100);
        r[7:4] = 4'((v % 100) / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    // One-cycle start pulse; returns at the negedge just after the accepting edge.
    task automatic drive_start(input int v, input bit push);
        @(negedge clk);
        bin   = 7'(v);
        start = 1'b1;
        if (push) sb.push_back(ref_bcd(v));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cycles, output bit seen);
        seen   = 1'b0;
        cycles = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                seen   = 1'b1;
                cycles = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        bin   = 7'd0;
        #12;
        total++;
        if ({busy, done, hundreds, tens, ones} !== 11'd0) begin
            bad++;
            $display("[TB] FAIL reset_state: got %b expected 0", {busy, done, hundreds, tens, ones});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_known_values();
        int vals[3] = '{78, 127, 0};
        int cyc;
        bit seen;
        logic [8:0] exp_v;
        foreach (vals[k]) begin
            drive_start(vals[k], 1'b1);
            total++;
            if (busy !== 1'b1) begin
                bad++;
                $display("[TB] FAIL known_busy bin=%0d: got %b expected 1", vals[k], busy);
            end
            wait_done(cyc, seen);
            total++;
            if (!seen || cyc !== 8) begin
                bad++;
                $display("[TB] FAIL known_latency bin=%0d: got seen=%0d cycles=%0d expected 8", vals[k], seen, cyc);
            end
            if (seen && sb.size() > 0) begin
                exp_v = sb.pop_front();
                total++;
                if ({hundreds, tens, ones} !== exp_v) begin
                    bad++;
                    $display("[TB] FAIL known_digits bin=%0d: got %h expected %h", vals[k], {hundreds, tens, ones}, exp_v);
                end
            end
            sb.delete();
            @(negedge clk);
            total++;
            if (done !== 1'b0) begin
                bad++;
                $display("[TB] FAIL known_done_width bin=%0d: got %b expected 0", vals[k], done);
            end
        end
    endtask

    task automatic test_start_during_busy();
        int cyc;
        bit seen;
        int extra;
        logic [8:0] exp_v;
        drive_start(45, 1'b1);
        for (int i = 0; i < 4; i++) begin
            bin   = 7'd99;
            start = 1'b1;
            total++;
            if (busy !== 1'b1) begin
                bad++;
                $display("[TB] FAIL ignore_busy step=%0d: got %b expected 1", i, busy);
            end
            @(negedge clk);
        end
        start = 1'b0;
        wait_done(cyc, seen);
        total++;
        if (!seen || cyc !== 4) begin
            bad++;
            $display("[TB] FAIL ignore_latency: got seen=%0d cycles=%0d expected 4", seen, cyc);
        end
        if (seen && sb.size() > 0) begin
            exp_v = sb.pop_front();
            total++;
            if ({hundreds, tens, ones} !== exp_v) begin
                bad++;
                $display("[TB] FAIL ignore_digits: got %h expected %h", {hundreds, tens, ones}, exp_v);
            end
        end
        sb.delete();
        extra = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done) extra++;
        end
        total++;
        if (extra !== 0) begin
            bad++;
            $display("[TB] FAIL ignore_extra_done: got %0d expected 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        int extra;
        int cyc;
        bit seen;
        logic [8:0] exp_v;
        drive_start(100, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, hundreds, tens, ones} !== 11'd0) begin
            bad++;
            $display("[TB] FAIL abort_clear: got %b expected 0", {busy, done, hundreds, tens, ones});
        end
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) extra++;
        end
        total++;
        if (extra !== 0 || {hundreds, tens, ones} !== 9'd0) begin
            bad++;
            $display("[TB] FAIL abort_no_done: got pulses=%0d digits=%h expected 0 and 000", extra, {hundreds, tens, ones});
        end
        drive_start(33, 1'b1);
        wait_done(cyc, seen);
        total++;
        if (!seen || cyc !== 8) begin
            bad++;
            $display("[TB] FAIL fresh_latency: got seen=%0d cycles=%0d expected 8", seen, cyc);
        end
        if (seen && sb.size() > 0) begin
            exp_v = sb.pop_front();
            total++;
            if ({hundreds, tens, ones} !== exp_v) begin
                bad++;
                $display("[TB] FAIL fresh_digits: got %h expected %h", {hundreds, tens, ones}, exp_v);
            end
        end
        sb.delete();
    endtask

    task automatic test_back_to_back();
        int first;
        int second;
        logic [8:0] exp_v;
        first  = 0;
        second = 0;
        @(negedge clk);
        bin   = 7'd9;
        start = 1'b1;
        sb.push_back(ref_bcd(9));
        sb.push_back(ref_bcd(10));
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 1) bin = 7'd10;
            if (first != 0 && i == first + 1) start = 1'b0;
            if (done) begin
                if (sb.size() > 0) begin
                    exp_v = sb.pop_front();
                    total++;
                    if ({hundreds, tens, ones} !== exp_v) begin
                        bad++;
                        $display("[TB] FAIL b2b_digits at %0d: got %h expected %h", i, {hundreds, tens, ones}, exp_v);
                    end
                end
                if (first == 0) first = i;
                else begin
                    second = i;
                    break;
                end
            end
        end
        start = 1'b0;
        total++;
        if (first !== 9 || second - first !== 9) begin
            bad++;
            $display("[TB] FAIL b2b_spacing: got first=%0d second=%0d expected 9 and 18", first, second);
        end
        sb.delete();
        repeat (12) @(negedge clk);
    endtask

    task automatic test_sweep();
        int cyc;
        bit seen;
        logic [8:0] exp_v;
        for (int v = 0; v < 128; v++) begin
            drive_start(v, 1'b1);
            wait_done(cyc, seen);
            total++;
            if (!seen) begin
                bad++;
                $display("[TB] FAIL sweep_timeout bin=%0d: got no done expected done", v);
                sb.delete();
                continue;
            end
            exp_v = sb.pop_front();
            if ({hundreds, tens, ones} !== exp_v) begin
                bad++;
                $display("[TB] FAIL sweep_digits bin=%0d: got %h expected %h", v, {hundreds, tens, ones}, exp_v);
            end
            @(negedge clk);
            total++;
            if (done !== 1'b0) begin
                bad++;
                $display("[TB] FAIL sweep_done_width bin=%0d: got %b expected 0", v, done);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_known_values();
        test_start_during_busy();
        test_reset_mid();
        test_back_to_back();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
